command_decoder: RTL
====================

COMMAND_DECODER -- requirements
Module: command_decoder

Interface
REQ-001 SHALL have parameter ADDRESS_BYTES, default 3: address field length in bytes (1..4).
REQ-002 SHALL have parameter VALUE_BYTES, default 4: value field length in bytes (1..8).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: inter-byte timeout in clk_i cycles; 0 disables the timeout.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk_i  in  1  sole clock, rising edge.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 spi_rx_valid_i  in  1  one-cycle strobe: spi_rx_byte_i valid.
REQ-008 spi_rx_byte_i  in  8  received SPI byte.
REQ-009 result_i  in  8*VALUE_BYTES  word served by TRANSFER.
REQ-010 stream_i  in  8*VALUE_BYTES  word served during STREAM.
REQ-011 cmd_valid_o  out  1  one-cycle pulse: decoded command on outputs.
REQ-012 instruction_o  out  8  decoded opcode.
REQ-013 address_o  out  8*ADDRESS_BYTES  decoded address.
REQ-014 value_o  out  8*VALUE_BYTES  decoded value.
REQ-015 spi_tx_byte_o  out  8  next byte for SPI transmit.
REQ-016 error_o  out  1  one-cycle pulse: unknown opcode or timeout abort.
REQ-017 busy_o  out  1  high while a multi-byte frame is being collected.

Function
REQ-018 FSM SHALL have states IDLE and COLLECT; busy_o = (state == COLLECT).
REQ-019 In IDLE, a strobed byte SHALL be treated as an opcode; the payload is received MSB-first.
REQ-020 Payload lengths: WRITE = ADDRESS_BYTES+VALUE_BYTES (address first); READ, BIND_INTERRUPT, BIND_READ_ADDRESS, BIND_WRITE_ADDRESS = ADDRESS_BYTES; STREAM = VALUE_BYTES; TRANSFER, REPEAT = 0.
REQ-021 A nonzero-payload opcode SHALL move the FSM to COLLECT and load the remaining count; each strobed byte shifts in and decrements the count.
REQ-022 On the strobe of the final payload byte, the next cycle SHALL pulse cmd_valid_o with the fields updated, and the FSM returns to IDLE.
REQ-023 Fields not carried by the opcode SHALL output 0 (READ and BIND_*: value_o=0; STREAM: address_o=0).
REQ-024 TRANSFER and REPEAT SHALL pulse cmd_valid_o one cycle after the strobe, with address_o=0 and value_o=0.
REQ-025 Outputs SHALL hold their last command between pulses.
REQ-026 TRANSFER: spi_tx_byte_o SHALL be set to result_i byte[ptr], then ptr decrements; ptr wraps from 0 to VALUE_BYTES-1.
REQ-027 REPEAT SHALL set ptr to VALUE_BYTES-1 without changing spi_tx_byte_o.
REQ-028 On STREAM opcode acceptance, stream_i SHALL be snapshotted and spi_tx_byte_o set to its MSB.
REQ-029 Each STREAM payload strobe SHALL advance spi_tx_byte_o to the next lower snapshot byte; after the last byte it holds.
REQ-030 An unknown opcode in IDLE SHALL pulse error_o the next cycle, stay IDLE and not pulse cmd_valid_o.
REQ-031 In COLLECT, if TIMEOUT_CYCLES>0 and TIMEOUT_CYCLES cycles pass with no strobe, the frame SHALL abort: pulse error_o, go IDLE, no cmd_valid_o, fields unchanged.
REQ-032 The timeout counter SHALL clear on every strobe and whenever the FSM is in IDLE.
REQ-033 Any byte value, including opcode codes, SHALL be accepted as payload in COLLECT.

Reset
REQ-034 rst_i SHALL asynchronously force: IDLE, ptr=VALUE_BYTES-1, all counters 0, and every output 0.
REQ-035 Reset mid-frame SHALL discard the partial frame with no cmd_valid_o or error_o pulse.

Structure
REQ-036 Opcode constants (WRITE 0x01, READ 0x02, STREAM 0x03, BIND_INTERRUPT 0x04, BIND_READ_ADDRESS 0x05, BIND_WRITE_ADDRESS 0x06, TRANSFER 0x07, REPEAT 0x08) SHALL live in shared package command_pkg.
REQ-037 command_pkg SHALL also hold the state typedef and a payload_length(opcode) function.
REQ-038 The timeout counter SHALL be sub-module idle_timer (clear, enable, expired).

Verification (defaults)
REQ-039 Strobe 01 12 34 56 DE AD BE EF -> one cmd_valid_o, instruction 0x01, address 0x123456, value 0xDEADBEEF.
REQ-040 result_i=0xA1B2C3D4, five TRANSFER opcodes -> tx A1,B2,C3,D4,A1; then REPEAT, TRANSFER -> A1.
REQ-041 stream_i=0x11223344 at the STREAM opcode (changed afterwards), payload 4 bytes -> tx 11,22,33,44; value_o = payload bytes.
REQ-042 Opcode 0xFF -> error_o pulse, no cmd_valid_o, busy_o low.
REQ-043 TIMEOUT_CYCLES=16: 02 12, idle 16 cycles -> error_o pulse; then 02 AA BB CC -> address 0xAABBCC.
REQ-044 rst_i after 01 12 34 -> outputs 0; then a full WRITE decodes correctly.

Source files
------------

// File: rtl/command_pkg.sv
// command_pkg: shared definitions for the SPI command decoder.
//   - opcode constants
//   - decoder FSM state type
//   - opcode_known():   true for the eight defined opcodes
//   - payload_length(): payload bytes following an opcode (0 for none/unknown)
package command_pkg;

    localparam logic [7:0] OP_WRITE              = 8'h01;
    localparam logic [7:0] OP_READ               = 8'h02;
    localparam logic [7:0] OP_STREAM             = 8'h03;
    localparam logic [7:0] OP_BIND_INTERRUPT     = 8'h04;
    localparam logic [7:0] OP_BIND_READ_ADDRESS  = 8'h05;
    localparam logic [7:0] OP_BIND_WRITE_ADDRESS = 8'h06;
    localparam logic [7:0] OP_TRANSFER           = 8'h07;
    localparam logic [7:0] OP_REPEAT             = 8'h08;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    function automatic logic opcode_known(input logic [7:0] opcode);
        return (opcode >= OP_WRITE) && (opcode <= OP_REPEAT);
    endfunction

    function automatic int unsigned payload_length(input logic [7:0]  opcode,
                                                   input int unsigned address_bytes,
                                                   input int unsigned value_bytes);
        case (opcode)
            OP_WRITE:              return address_bytes + value_bytes;
            OP_READ,
            OP_BIND_INTERRUPT,
            OP_BIND_READ_ADDRESS,
            OP_BIND_WRITE_ADDRESS: return address_bytes;
            OP_STREAM:             return value_bytes;
            default:               return 0;
        endcase
    endfunction

endpackage

// File: rtl/idle_timer.sv
// idle_timer: counts consecutive enabled cycles; expired is asserted during
// the TIMEOUT_CYCLES-th enabled cycle since the last clear.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   clear   : synchronous counter clear (dominates enable)
//   enable  : count this cycle
//   expired : timeout reached (never asserted when TIMEOUT_CYCLES == 0)
module idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    if (TIMEOUT_CYCLES == 0) begin : g_disabled
        logic unused_inputs;
        assign unused_inputs = ^{clk_i, rst_i, clear, enable};
        assign expired       = 1'b0;
    end else begin : g_enabled
        localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

        logic [CW-1:0] count_q;

        assign expired = enable && (count_q == CW'(TIMEOUT_CYCLES - 1));

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                count_q <= '0;
            end else if (clear) begin
                count_q <= '0;
            end else if (enable && !expired) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/command_decoder.sv
// command_decoder: decodes opcode + MSB-first payload frames received over SPI
// and serves transmit bytes for TRANSFER / STREAM.
//   clk_i, rst_i     : clock (rising edge), asynchronous active-high reset
//   spi_rx_valid_i   : one-cycle strobe qualifying spi_rx_byte_i
//   spi_rx_byte_i    : received byte
//   result_i         : word served byte-by-byte by TRANSFER
//   stream_i         : word snapshotted by STREAM
//   cmd_valid_o      : one-cycle pulse, decoded command on the field outputs
//   instruction_o    : decoded opcode
//   address_o        : decoded address (0 when the opcode carries none)
//   value_o          : decoded value (0 when the opcode carries none)
//   spi_tx_byte_o    : next byte for SPI transmit
//   error_o          : one-cycle pulse, unknown opcode or inter-byte timeout
//   busy_o           : frame collection in progress
module command_decoder
    import command_pkg::*;
#(
    parameter int unsigned ADDRESS_BYTES  = 3,
    parameter int unsigned VALUE_BYTES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       spi_rx_valid_i,
    input  logic [7:0]                 spi_rx_byte_i,
    input  logic [8*VALUE_BYTES-1:0]   result_i,
    input  logic [8*VALUE_BYTES-1:0]   stream_i,
    output logic                       cmd_valid_o,
    output logic [7:0]                 instruction_o,
    output logic [8*ADDRESS_BYTES-1:0] address_o,
    output logic [8*VALUE_BYTES-1:0]   value_o,
    output logic [7:0]                 spi_tx_byte_o,
    output logic                       error_o,
    output logic                       busy_o
);

    localparam int unsigned AW   = 8 * ADDRESS_BYTES;
    localparam int unsigned VW   = 8 * VALUE_BYTES;
    localparam int unsigned SW   = AW + VW;
    localparam int unsigned CNTW = $clog2(ADDRESS_BYTES + VALUE_BYTES + 1);
    localparam int unsigned PW   = (VALUE_BYTES > 1) ? $clog2(VALUE_BYTES) : 1;

    state_t          state_q, state_d;
    logic [CNTW-1:0] remaining_q;
    logic [CNTW-1:0] op_len;
    logic [7:0]      opcode_q;
    logic [SW-1:0]   shift_q;
    logic [SW-1:0]   shift_next;
    logic [PW-1:0]   ptr_q;
    logic [VW-1:0]   snap_q;
    logic [PW-1:0]   snap_idx_q;
    logic            final_byte;
    logic            timeout_abort;
    logic            timer_expired;

    assign busy_o     = (state_q == COLLECT);
    assign shift_next = {shift_q[SW-9:0], spi_rx_byte_i};

    idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  ((state_q == IDLE) || spi_rx_valid_i),
        .enable ((state_q == COLLECT) && !spi_rx_valid_i),
        .expired(timer_expired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        final_byte    = 1'b0;
        timeout_abort = 1'b0;
        op_len        = CNTW'(payload_length(spi_rx_byte_i, ADDRESS_BYTES, VALUE_BYTES));
        case (state_q)
            IDLE: begin
                if (spi_rx_valid_i && (op_len != '0)) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (spi_rx_valid_i) begin
                    if (remaining_q == CNTW'(1)) begin
                        final_byte = 1'b1;
                        state_d    = IDLE;
                    end
                end else if (timer_expired) begin
                    timeout_abort = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            remaining_q   <= '0;
            opcode_q      <= '0;
            shift_q       <= '0;
            ptr_q         <= PW'(VALUE_BYTES - 1);
            snap_q        <= '0;
            snap_idx_q    <= '0;
            cmd_valid_o   <= 1'b0;
            instruction_o <= '0;
            address_o     <= '0;
            value_o       <= '0;
            spi_tx_byte_o <= '0;
            error_o       <= 1'b0;
        end else begin
            cmd_valid_o <= 1'b0;
            error_o     <= timeout_abort;
            if (spi_rx_valid_i) begin
                if (state_q == IDLE) begin
                    opcode_q    <= spi_rx_byte_i;
                    remaining_q <= op_len;
                    shift_q     <= '0;
                    if (!opcode_known(spi_rx_byte_i)) begin
                        error_o <= 1'b1;
                    end
                    case (spi_rx_byte_i)
                        OP_TRANSFER: begin
                            cmd_valid_o   <= 1'b1;
                            instruction_o <= spi_rx_byte_i;
                            address_o     <= '0;
                            value_o       <= '0;
                            spi_tx_byte_o <= result_i[8*ptr_q +: 8];
                            ptr_q         <= (ptr_q == '0) ? PW'(VALUE_BYTES - 1) : ptr_q - 1'b1;
                        end
                        OP_REPEAT: begin
                            cmd_valid_o   <= 1'b1;
                            instruction_o <= spi_rx_byte_i;
                            address_o     <= '0;
                            value_o       <= '0;
                            ptr_q         <= PW'(VALUE_BYTES - 1);
                        end
                        OP_STREAM: begin
                            snap_q        <= stream_i;
                            snap_idx_q    <= PW'(VALUE_BYTES - 1);
                            spi_tx_byte_o <= stream_i[VW-1 -: 8];
                        end
                        default: ;
                    endcase
                end else begin
                    shift_q     <= shift_next;
                    remaining_q <= remaining_q - 1'b1;
                    // snap_idx_q names the snapshot byte currently on spi_tx_byte_o;
                    // once byte 0 has been presented the output holds.
                    if ((opcode_q == OP_STREAM) && (snap_idx_q != '0)) begin
                        snap_idx_q    <= snap_idx_q - 1'b1;
                        spi_tx_byte_o <= snap_q[8*(snap_idx_q - 1'b1) +: 8];
                    end
                    // Fields are taken from shift_next so the final byte is included.
                    if (final_byte) begin
                        cmd_valid_o   <= 1'b1;
                        instruction_o <= opcode_q;
                        case (opcode_q)
                            OP_WRITE: begin
                                address_o <= shift_next[SW-1 -: AW];
                                value_o   <= shift_next[VW-1:0];
                            end
                            OP_STREAM: begin
                                address_o <= '0;
                                value_o   <= shift_next[VW-1:0];
                            end
                            default: begin
                                address_o <= shift_next[AW-1:0];
                                value_o   <= '0;
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule
